// File: rtl/dense_neuron_requant.sv
// One quantized dense neuron: zero-point MAC through an external multiplier, bias, ReLU, requant to int8.
// Last beat at T gives o_valid at T+5 (len 0: start+4); o_ready only in MAC, result held until i_ready.
module dense_neuron_requant #(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_input_zp,
  input  logic [7:0]       i_filter_zp,
  input  logic [7:0]       i_output_zp,
  input  logic [31:0]      i_bias,
  input  logic [31:0]      i_quant_mult,
  input  logic [7:0]       i_quant_shift,
  input  logic             i_relu_en,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [7:0]       i_act,
  input  logic [7:0]       i_wt,
  output logic [15:0]      o_mul_a,
  output logic [15:0]      o_mul_b,
  input  logic [31:0]      i_mul_p,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [7:0]       o_data,
  output logic             o_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_SCALE = 3'd4;
  localparam logic [2:0] S_SHIFT = 3'd5;
  localparam logic [2:0] S_OUT   = 3'd6;

  logic [2:0]         r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [7:0]         r_izp;
  logic [7:0]         r_fzp;
  logic [7:0]         r_ozp;
  logic [31:0]        r_bias;
  logic [31:0]        r_qmult;
  logic [5:0]         r_tshift;
  logic               r_relu;
  logic               r_pend;
  logic [31:0]        r_acc;
  logic [31:0]        r_r32;
  logic signed [63:0] r_p64;
  logic [15:0]        r_mul_a;
  logic [15:0]        r_mul_b;
  logic [7:0]         r_data;

  logic               w_hs;
  logic [LEN_W-1:0]   w_cnt_nxt;
  logic [15:0]        w_a;
  logic [15:0]        w_b;
  logic [31:0]        w_r32;
  logic [31:0]        w_r32_act;
  logic signed [63:0] w_r64;
  logic signed [63:0] w_q64;
  logic signed [63:0] w_rnd;
  logic signed [63:0] w_p64;
  logic [7:0]         w_sh8;

  assign o_ready   = (r_state == S_MAC);
  assign o_valid   = (r_state == S_OUT);
  assign o_busy    = (r_state != S_IDLE);
  assign o_mul_a   = r_mul_a;
  assign o_mul_b   = r_mul_b;
  assign o_data    = r_data;

  assign w_hs      = i_valid && o_ready;
  assign w_cnt_nxt = r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
  // 8-bit operands sign-extended to 16 bits, so the difference can never overflow
  assign w_a       = {{8{i_act[7]}}, i_act} - {{8{r_izp[7]}}, r_izp};
  assign w_b       = {{8{i_wt[7]}}, i_wt} - {{8{r_fzp[7]}}, r_fzp};

  assign w_r32     = r_acc + r_bias;
  assign w_r32_act = (r_relu && w_r32[31]) ? 32'd0 : w_r32;
  assign w_r64     = {{32{r_r32[31]}}, r_r32};
  assign w_q64     = {{32{r_qmult[31]}}, r_qmult};
  assign w_rnd     = 64'sd1 <<< (r_tshift - 6'd1);
  assign w_p64     = w_r64 * w_q64 + w_rnd;
  // only the low byte survives, so output_zp is added after truncation
  assign w_sh8     = 8'(r_p64 >>> r_tshift);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_izp    <= '0;
      r_fzp    <= '0;
      r_ozp    <= '0;
      r_bias   <= '0;
      r_qmult  <= '0;
      r_tshift <= '0;
      r_relu   <= 1'b0;
      r_pend   <= 1'b0;
      r_acc    <= '0;
      r_r32    <= '0;
      r_p64    <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len    <= i_len;
            r_izp    <= i_input_zp;
            r_fzp    <= i_filter_zp;
            r_ozp    <= i_output_zp;
            r_bias   <= i_bias;
            r_qmult  <= i_quant_mult;
            r_tshift <= 6'(8'sd31 - i_quant_shift);
            r_relu   <= i_relu_en;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
            r_state  <= (i_len == '0) ? S_BIAS : S_MAC;
          end
        end
        S_MAC: begin
          if (r_pend) r_acc <= r_acc + i_mul_p;
          if (w_hs) begin
            r_mul_a <= w_a;
            r_mul_b <= w_b;
            r_pend  <= 1'b1;
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) r_state <= S_DRAIN;
          end else begin
            r_pend <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_pend) r_acc <= r_acc + i_mul_p;
          r_pend  <= 1'b0;
          r_state <= S_BIAS;
        end
        S_BIAS: begin
          r_r32   <= w_r32_act;
          r_state <= S_SCALE;
        end
        S_SCALE: begin
          r_p64   <= w_p64;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_data  <= w_sh8 + r_ozp;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (i_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
